dist_regfile_mp: RTL and testbench

- Next-generation distribution register file for the RV32I distribution datapath.
- Parametrised width and depth, two independent registered read ports, and lane-masked writes.
- Write-to-read forwarding is merged lane by lane.
- A hardware bulk-clear sequencer zeroes every entry after reset or on request; `busy` is asserted while it runs.
- Sits beside the integer register file; feeds the distribution ALU operand latches.

---
 rtl/dist_regfile_pkg.sv | 18 +
 rtl/dist_rd_port.sv | 62 ++++++
 rtl/dist_regfile_mp.sv | 159 +++++++++++++++
 tb/tb_dist_regfile_mp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_regfile_pkg.sv
// Shared definitions for the distribution register file: clear-FSM encoding,
// default geometry and the lane-count helper.
package dist_regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clrState_t;

    localparam int DEF_DATA_W = 256;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_LANE_W = 32;

    function automatic int lanesOf(input int dataW, input int laneW);
        return dataW / laneW;
    endfunction

endpackage

// File: rtl/dist_rd_port.sv
// One registered read port: buffers address, array data and busy snapshot,
// then merges the buffered write lane by lane when the addresses match.
module dist_rd_port
    import dist_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 5,
    parameter int LANE_W = DEF_LANE_W,
    parameter int LANES  = lanesOf(DEF_DATA_W, DEF_LANE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] arrData,
    input  logic              busy,
    input  logic              wrEnBuf,
    input  logic [ADDR_W-1:0] wrAddrBuf,
    input  logic [LANES-1:0]  wrMaskBuf,
    input  logic [DATA_W-1:0] wrDataBuf,
    output logic [DATA_W-1:0] rdData
);

    logic [ADDR_W-1:0] addrBuf_r;
    logic [DATA_W-1:0] dataReg_r;
    logic              busySnap_r;
    logic              fwdHit_s;
    logic [DATA_W-1:0] rdData_s;

    // Capture the array word, its address and whether the clear walk was running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addrBuf_r  <= {ADDR_W{1'b0}};
            dataReg_r  <= {DATA_W{1'b0}};
            busySnap_r <= 1'b0;
        end else begin
            addrBuf_r  <= rdAddr;
            dataReg_r  <= arrData;
            busySnap_r <= busy;
        end
    end

    assign fwdHit_s = wrEnBuf && (wrAddrBuf == addrBuf_r);

    // Lane-wise forwarding mux; reads taken during the clear walk return zero.
    always_comb begin
        rdData_s = {DATA_W{1'b0}};
        if (busySnap_r) begin
            rdData_s = {DATA_W{1'b0}};
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (fwdHit_s && wrMaskBuf[i]) begin
                    rdData_s[i*LANE_W +: LANE_W] = wrDataBuf[i*LANE_W +: LANE_W];
                end else begin
                    rdData_s[i*LANE_W +: LANE_W] = dataReg_r[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdData = rdData_s;

endmodule

// File: rtl/dist_regfile_mp.sv
// Distribution register file: lane-masked write port, two forwarding read
// ports and a sequencer that zeroes every entry after reset or on request.
module dist_regfile_mp
    import dist_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = 5,
    parameter int LANE_W = DEF_LANE_W,
    localparam int LANES = lanesOf(DATA_W, LANE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clrReq,
    input  logic              DRegWrite,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [LANES-1:0]  wrMask,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    output logic [DATA_W-1:0] rdDataA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataB,
    output logic              busy,
    output logic              wrDrop
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] regFile_r [DEPTH];

    clrState_t         state_r;
    clrState_t         nextState_s;
    logic [ADDR_W-1:0] clrPtr_r;
    logic [ADDR_W-1:0] nextPtr_s;

    logic              wrEff_s;
    logic              wrDiscard_s;
    logic              clrWrite_s;
    logic              wrDrop_r;

    logic              wrEnBuf_r;
    logic [ADDR_W-1:0] wrAddrBuf_r;
    logic [LANES-1:0]  wrMaskBuf_r;
    logic [DATA_W-1:0] wrDataBuf_r;

    // A clear request in the same cycle as a write takes priority and drops the write.
    assign wrEff_s     = rst_n && (state_r == IDLE) && DRegWrite && !clrReq;
    assign wrDiscard_s = DRegWrite && ((state_r == CLEAR) || clrReq);
    assign clrWrite_s  = rst_n && (state_r == CLEAR);
    assign busy        = (state_r == CLEAR);

    // Clear sequencer state and walk pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= CLEAR;
            clrPtr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= nextState_s;
            clrPtr_r <= nextPtr_s;
        end
    end

    // Next-state logic: one entry zeroed per cycle, back to IDLE after the last.
    always_comb begin
        nextState_s = state_r;
        nextPtr_s   = clrPtr_r;
        case (state_r)
            IDLE: begin
                if (clrReq) begin
                    nextState_s = CLEAR;
                    nextPtr_s   = {ADDR_W{1'b0}};
                end else begin
                    nextState_s = IDLE;
                end
            end
            CLEAR: begin
                if (clrPtr_r == LAST_ADDR) begin
                    nextState_s = IDLE;
                    nextPtr_s   = {ADDR_W{1'b0}};
                end else begin
                    nextPtr_s   = clrPtr_r + ADDR_W'(1);
                end
            end
            default: begin
                nextState_s = CLEAR;
                nextPtr_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Storage array; contents are only ever zeroed by the clear walk.
    always_ff @(posedge clk) begin
        if (clrWrite_s) begin
            regFile_r[clrPtr_r] <= {DATA_W{1'b0}};
        end else if (wrEff_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (wrMask[i]) begin
                    regFile_r[wrAddr][i*LANE_W +: LANE_W] <= wrData[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Write-port buffer feeding the read-port forwarding muxes, plus the drop pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrEnBuf_r   <= 1'b0;
            wrAddrBuf_r <= {ADDR_W{1'b0}};
            wrMaskBuf_r <= {LANES{1'b0}};
            wrDataBuf_r <= {DATA_W{1'b0}};
            wrDrop_r    <= 1'b0;
        end else begin
            wrEnBuf_r   <= wrEff_s;
            wrAddrBuf_r <= wrAddr;
            wrMaskBuf_r <= wrMask;
            wrDataBuf_r <= wrData;
            wrDrop_r    <= wrDiscard_s;
        end
    end

    assign wrDrop = wrDrop_r;

    dist_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) portA (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdAddr    (rdAddrA),
        .arrData   (regFile_r[rdAddrA]),
        .busy      (busy),
        .wrEnBuf   (wrEnBuf_r),
        .wrAddrBuf (wrAddrBuf_r),
        .wrMaskBuf (wrMaskBuf_r),
        .wrDataBuf (wrDataBuf_r),
        .rdData    (rdDataA)
    );

    dist_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) portB (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdAddr    (rdAddrB),
        .arrData   (regFile_r[rdAddrB]),
        .busy      (busy),
        .wrEnBuf   (wrEnBuf_r),
        .wrAddrBuf (wrAddrBuf_r),
        .wrMaskBuf (wrMaskBuf_r),
        .wrDataBuf (wrDataBuf_r),
        .rdData    (rdDataB)
    );

endmodule

// File: tb/tb_dist_regfile_mp.sv
// Directed bench for dist_regfile_mp: a reference model predicts every cycle's
// outputs into a scoreboard queue, plus targeted checks on each scenario.
module tb_dist_regfile_mp;

    localparam int DW    = 256;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int LW    = 32;
    localparam int LN    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clrReq;
    logic          DRegWrite;
    logic [AW-1:0] wrAddr;
    logic [LN-1:0] wrMask;
    logic [DW-1:0] wrData;
    logic [AW-1:0] rdAddrA;
    logic [DW-1:0] rdDataA;
    logic [AW-1:0] rdAddrB;
    logic [DW-1:0] rdDataB;
    logic          busy;
    logic          wrDrop;

    always #5 clk = ~clk;

    dist_regfile_mp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clrReq    (clrReq),
        .DRegWrite (DRegWrite),
        .wrAddr    (wrAddr),
        .wrMask    (wrMask),
        .wrData    (wrData),
        .rdAddrA   (rdAddrA),
        .rdDataA   (rdDataA),
        .rdAddrB   (rdAddrB),
        .rdDataB   (rdDataB),
        .busy      (busy),
        .wrDrop    (wrDrop)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          drop;
        logic          busy;
    } exp_t;

    exp_t          expQ[$];
    logic [DW-1:0] mem [DEPTH];
    logic          mClear;
    int            mPtr;
    int            errors = 0;
    int            checks = 0;
    int            n;

    localparam logic [DW-1:0] ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0] PAT_A = {8{32'hAAAAAAAA}};
    localparam logic [DW-1:0] PAT_1 = {8{32'h11111111}};
    localparam logic [DW-1:0] PAT_4 = {8{32'h44444444}};
    localparam logic [DW-1:0] PAT_3 = {8{32'h33333333}};
    localparam logic [DW-1:0] PAT_7 = {8{32'h77777777}};
    localparam logic [DW-1:0] PAT_C = {8{32'hCCCCCCCC}};

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] oldV,
                                            input logic [DW-1:0] newV,
                                            input logic [LN-1:0] mask);
        logic [DW-1:0] r;
        r = oldV;
        for (int i = 0; i < LN; i++) begin
            if (mask[i]) r[i*LW +: LW] = newV[i*LW +: LW];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Predict this cycle's outcome, clock once, then compare against the scoreboard.
    task automatic step();
        exp_t e;
        logic wrEff;
        wrEff  = rst_n && !mClear && DRegWrite && !clrReq;
        e.a    = (!rst_n || mClear) ? ZERO :
                 (wrEff && wrAddr == rdAddrA) ? merge(mem[rdAddrA], wrData, wrMask) : mem[rdAddrA];
        e.b    = (!rst_n || mClear) ? ZERO :
                 (wrEff && wrAddr == rdAddrB) ? merge(mem[rdAddrB], wrData, wrMask) : mem[rdAddrB];
        e.drop = rst_n && DRegWrite && (mClear || clrReq);
        if (!rst_n) begin
            mClear = 1'b1;
            mPtr   = 0;
        end else if (mClear) begin
            mem[mPtr] = ZERO;
            if (mPtr == DEPTH - 1) mClear = 1'b0;
            else mPtr++;
        end else if (clrReq) begin
            mClear = 1'b1;
            mPtr   = 0;
        end else if (wrEff) begin
            mem[wrAddr] = merge(mem[wrAddr], wrData, wrMask);
        end
        e.busy = mClear;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        chk("sb_rdDataA", rdDataA, e.a);
        chk("sb_rdDataB", rdDataB, e.b);
        chk("sb_wrDrop", DW'(wrDrop), DW'(e.drop));
        chk("sb_busy", DW'(busy), DW'(e.busy));
    endtask

    task automatic quiet();
        rst_n     = 1'b1;
        clrReq    = 1'b0;
        DRegWrite = 1'b0;
        wrMask    = 8'h00;
        wrData    = ZERO;
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [LN-1:0] m, input logic [DW-1:0] d);
        quiet();
        DRegWrite = 1'b1;
        wrAddr    = a;
        wrMask    = m;
        wrData    = d;
        step();
        quiet();
    endtask

    // Step until busy drops (bounded); count includes steps already taken.
    task automatic waitIdle(inout int cnt);
        while (busy === 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {DW{1'bx}};
        mClear  = 1'bx;
        mPtr    = 0;
        quiet();
        wrAddr  = 5'd0;
        rdAddrA = 5'd0;
        rdAddrB = 5'd0;

        // Reset for two cycles, then a write during the walk is dropped.
        rst_n = 1'b0;
        step();
        step();
        chk("reset_busy", DW'(busy), DW'(1'b1));
        chk("reset_rdA", rdDataA, ZERO);
        rst_n     = 1'b1;
        DRegWrite = 1'b1;
        wrAddr    = 5'd12;
        wrMask    = 8'hFF;
        wrData    = PAT_C;
        step();
        chk("busy_write_drop", DW'(wrDrop), DW'(1'b1));
        quiet();
        n = 1;
        waitIdle(n);
        chk("reset_walk_len", DW'(n), DW'(32));
        rdAddrA = 5'd0;  rdAddrB = 5'd17; step();
        chk("clr_rd0", rdDataA, ZERO);
        chk("clr_rd17", rdDataB, ZERO);
        rdAddrA = 5'd31; rdAddrB = 5'd12; step();
        chk("clr_rd31", rdDataA, ZERO);
        chk("dropped_addr12", rdDataB, ZERO);

        // Masked write with lane-wise forwarding.
        doWrite(5'd5, 8'hFF, PAT_A);
        rdAddrA = 5'd5;
        DRegWrite = 1'b1; wrAddr = 5'd5; wrMask = 8'h0F; wrData = PAT_1;
        step();
        quiet();
        chk("fwd_masked", rdDataA, {{4{32'hAAAAAAAA}}, {4{32'h11111111}}});
        step();
        chk("array_masked", rdDataA, {{4{32'hAAAAAAAA}}, {4{32'h11111111}}});

        // Dual-port independence.
        doWrite(5'd4, 8'hFF, PAT_4);
        rdAddrA = 5'd3; rdAddrB = 5'd4;
        DRegWrite = 1'b1; wrAddr = 5'd3; wrMask = 8'hFF; wrData = PAT_3;
        step();
        quiet();
        chk("dual_fwd_A", rdDataA, PAT_3);
        chk("dual_B_stored", rdDataB, PAT_4);
        rdAddrA = 5'd4; rdAddrB = 5'd4; step();
        chk("same_addr_A", rdDataA, PAT_4);
        chk("same_addr_B", rdDataB, PAT_4);

        // Unmasked write is a no-op and not a drop.
        doWrite(5'd7, 8'hFF, PAT_7);
        rdAddrA = 5'd7;
        DRegWrite = 1'b1; wrAddr = 5'd7; wrMask = 8'h00; wrData = PAT_C;
        step();
        quiet();
        chk("noop_rdA", rdDataA, PAT_7);
        chk("noop_drop", DW'(wrDrop), DW'(1'b0));

        // Clear request collides with a write: clear wins.
        doWrite(5'd9, 8'hFF, PAT_C);
        clrReq = 1'b1; DRegWrite = 1'b1; wrAddr = 5'd9; wrMask = 8'hFF; wrData = PAT_1;
        step();
        quiet();
        chk("collide_drop", DW'(wrDrop), DW'(1'b1));
        chk("collide_busy", DW'(busy), DW'(1'b1));
        clrReq = 1'b1; step(); quiet();
        n = 1;
        waitIdle(n);
        chk("collide_walk_len", DW'(n), DW'(32));
        rdAddrA = 5'd9; rdAddrB = 5'd5; step();
        chk("collide_rd9", rdDataA, ZERO);
        chk("collide_rd5", rdDataB, ZERO);

        // Reset partway through a clear restarts the walk.
        doWrite(5'd20, 8'hFF, PAT_C);
        clrReq = 1'b1; step(); quiet();
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n = 0;
        waitIdle(n);
        chk("midclr_walk_len", DW'(n), DW'(32));
        for (int i = 0; i < DEPTH; i += 2) begin
            rdAddrA = AW'(i); rdAddrB = AW'(i + 1); step();
            chk("midclr_rdA", rdDataA, ZERO);
            chk("midclr_rdB", rdDataB, ZERO);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
